// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C configuration sequencer.
package i2c_pkg;

    localparam int REGDATA_W = 27;

    typedef enum logic [2:0] {
        S_PWRUP    = 3'd0,
        S_IDLE     = 3'd1,
        S_LOAD     = 3'd2,
        S_LAUNCH   = 3'd3,
        S_WAIT_END = 3'd4,
        S_GAP      = 3'd5,
        S_DONE     = 3'd6,
        S_FAIL     = 3'd7
    } seq_state_e;

    // Ones after each byte leave the slave's ack slot released on the bus.
    function automatic logic [REGDATA_W-1:0] pack_regdata(input logic [23:0] d);
        return {d[23:16], 1'b1, d[15:8], 1'b1, d[7:0], 1'b1};
    endfunction

endpackage

// File: rtl/config_rom.sv
// Codec register initialisation table: {slave_addr, reg, data} per index.
module config_rom
    import i2c_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] rom_idx,
    output logic [23:0]      rom_data
);

    // Table lookup; unused indices read as zero
    always_comb begin
        rom_data = 24'h0;
        case (rom_idx)
            IDX_W'(0):  rom_data = 24'hA0_1F_55;
            IDX_W'(1):  rom_data = 24'h34_1E_00;
            IDX_W'(2):  rom_data = 24'h34_0C_10;
            IDX_W'(3):  rom_data = 24'h34_00_1A;
            IDX_W'(4):  rom_data = 24'h34_02_1A;
            IDX_W'(5):  rom_data = 24'h34_04_79;
            IDX_W'(6):  rom_data = 24'h34_06_79;
            IDX_W'(7):  rom_data = 24'h34_08_12;
            IDX_W'(8):  rom_data = 24'h34_0A_06;
            IDX_W'(9):  rom_data = 24'h34_10_00;
            IDX_W'(10): rom_data = 24'h34_12_01;
            default:    rom_data = 24'h0;
        endcase
    end

endmodule

// File: rtl/i2c_config_seq.sv
// Walks the config table through the I2C_write engine with retry, bus gap
// and timeout handling; reports done / error with the failing index.
module i2c_config_seq
    import i2c_pkg::*;
#(
    parameter int NUM_ENTRIES    = 11,
    parameter int IDX_W          = 4,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 1000,
    parameter int PWRUP_CYCLES   = 20000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    output logic [IDX_W-1:0]     rom_idx,
    input  logic [23:0]          rom_data,
    output logic [REGDATA_W-1:0] regdata,
    output logic                 GO,
    input  logic                 END,
    input  logic                 ACK,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [IDX_W-1:0]     fail_idx
);

    // One counter serves power-up delay, bus gap and END timeout; only one is live at a time.
    localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES)
        ? ((PWRUP_CYCLES > TIMEOUT_CYCLES) ? PWRUP_CYCLES : TIMEOUT_CYCLES)
        : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam int RT_W  = $clog2(MAX_RETRY + 1) + 1;

    seq_state_e             state_r, state_nxt;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt;
    logic [RT_W-1:0]        retry_r, retry_nxt;
    logic [IDX_W-1:0]       idx_r, idx_nxt;
    logic [IDX_W-1:0]       fail_idx_r, fail_idx_nxt;
    logic [REGDATA_W-1:0]   regdata_r, regdata_nxt;
    logic                   go_r, busy_r, done_r, error_r;
    logic                   go_nxt, busy_nxt, done_nxt, error_nxt;
    logic                   timeout_s;

    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, counter and output decode
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = CNT_W'(0);
        retry_nxt    = retry_r;
        idx_nxt      = idx_r;
        fail_idx_nxt = fail_idx_r;
        regdata_nxt  = regdata_r;
        done_nxt     = done_r;
        error_nxt    = error_r;
        case (state_r)
            S_PWRUP: begin
                if (cnt_r == CNT_W'(PWRUP_CYCLES - 1)) begin
                    state_nxt = S_LOAD;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (start) begin
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                    retry_nxt = RT_W'(0);
                    idx_nxt   = IDX_W'(0);
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                regdata_nxt = pack_regdata(rom_data);
                state_nxt   = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT_END;
            end
            S_WAIT_END: begin
                // END wins over a coincident timeout
                if (END && !ACK) begin
                    retry_nxt = RT_W'(0);
                    if (idx_r == IDX_W'(NUM_ENTRIES - 1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx_r + IDX_W'(1);
                        state_nxt = S_GAP;
                    end
                end else if (END || timeout_s) begin
                    if (retry_r < RT_W'(MAX_RETRY)) begin
                        retry_nxt = retry_r + RT_W'(1);
                        state_nxt = S_GAP;
                    end else begin
                        fail_idx_nxt = idx_r;
                        error_nxt    = 1'b1;
                        state_nxt    = S_FAIL;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
                    state_nxt = S_LOAD;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_PWRUP;
        endcase
        go_nxt   = (state_nxt == S_LAUNCH);
        busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_LAUNCH) ||
                   (state_nxt == S_WAIT_END) || (state_nxt == S_GAP);
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r    <= S_PWRUP;
            cnt_r      <= CNT_W'(0);
            retry_r    <= RT_W'(0);
            idx_r      <= IDX_W'(0);
            fail_idx_r <= IDX_W'(0);
            regdata_r  <= REGDATA_W'(0);
            go_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            cnt_r      <= cnt_nxt;
            retry_r    <= retry_nxt;
            idx_r      <= idx_nxt;
            fail_idx_r <= fail_idx_nxt;
            regdata_r  <= regdata_nxt;
            go_r       <= go_nxt;
            busy_r     <= busy_nxt;
            done_r     <= done_nxt;
            error_r    <= error_nxt;
        end
    end

    assign rom_idx  = idx_r;
    assign regdata  = regdata_r;
    assign GO       = go_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign error    = error_r;
    assign fail_idx = fail_idx_r;

endmodule
